// File: rtl/adder_sched_pkg.sv
// ----------------------------------------------------------------------------
// adder_sched_pkg
//
// Purpose:
//   Shared definitions for the round-robin scheduled adder.
//   - Operation-counter width and saturation value.
//   - Result-buffer state encoding.
//   - A round-robin pick helper for the arbiter.
//
// Ports:
//   None (package).
// ----------------------------------------------------------------------------
package adder_sched_pkg;

    // Width and saturation ceiling of the accepted-operation counter.
    localparam int              OPCNT_W   = 16;
    localparam logic [15:0]     OPCNT_MAX = 16'hFFFF;

    // The arbiter helper always works on a 4-wide request vector.
    // This covers the widest legal requester count.
    // Narrower configurations zero-pad their requests into it.
    localparam int MAX_NREQ = 4;
    localparam int MAX_IDW  = 2;

    // The result buffer is depth 1, so it is either holding a result or not.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Winner index plus a flag saying whether any request was found at all.
    typedef struct packed {
        logic                found;
        logic [MAX_IDW-1:0]  idx;
    } rr_pick_t;

    // Round-robin pick.
    // The search starts at ptr and wraps modulo nreq.
    // The first valid requester encountered wins.
    // Only the low nreq bits of valid are considered.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IDW-1:0]  ptr,
        input int                  nreq
    );
        rr_pick_t res;
        int       cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq) begin
                cand = (int'(ptr) + k) % nreq;
                if (!res.found && valid[cand[MAX_IDW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_IDW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_rr_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose:
//   Purely combinational round-robin arbiter.
//   Given the request vector and the current priority pointer, it returns
//   the index of the winning requester and whether any requester is active.
//   Updating the pointer is left to the caller.
//   This lets the caller advance the pointer only when a grant is actually
//   consumed.
//
// Ports:
//   req    in   NREQ  request vector (one bit per requester)
//   ptr    in   IDW   index that has highest priority this cycle
//   grant  out  IDW   index of the winning requester (0 when none)
//   any    out  1     at least one request bit is set
// ----------------------------------------------------------------------------
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any
);

    logic [MAX_NREQ-1:0] req_pad;
    logic [MAX_IDW-1:0]  ptr_pad;
    rr_pick_t            pick;

    // Widen the request vector and pointer to the helper's fixed width.
    // Unused upper request bits are zero, so they can never win.
    assign req_pad = MAX_NREQ'(req);
    assign ptr_pad = MAX_IDW'(ptr);

    // The search itself lives in the package so other blocks can reuse it.
    always_comb begin
        pick  = rr_pick(req_pad, ptr_pad, NREQ);
        grant = IDW'(pick.idx);
        any   = pick.found;
    end

endmodule

// File: rtl/adder_rr_sched.sv
// ----------------------------------------------------------------------------
// adder_rr_sched
//
// Purpose:
//   Shares one WIDTH-bit adder between NREQ requesters.
//   Each requester uses a valid/ready handshake.
//   A round-robin arbiter picks one requester per cycle.
//   The sum is registered into a depth-1 result buffer, tagged with the
//   winning requester's id.
//   The buffer supports pass-through refill: a full buffer that is being
//   drained can accept a new operation in the same cycle.
//   This allows one operation per cycle while res_ready stays high.
//
// Ports:
//   clk        in   1           clock, all state on rising edge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NREQ        per-requester operand valid
//   req_ready  out  NREQ        per-requester accept, at most one bit set
//   req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   res_valid  out  1           result buffer full
//   res_ready  in   1           consumer accepts result
//   res_sum    out  WIDTH       registered sum (wrapped or saturated)
//   res_carry  out  1           registered raw carry-out of the add
//   res_id     out  IDW         requester that produced the result
//   op_count   out  16          accepted operations, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int SAT   = 0,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WIDTH-1:0]        res_sum,
    output logic                    res_carry,
    output logic [IDW-1:0]          res_id,
    output logic [OPCNT_W-1:0]      op_count
);

    buf_state_t          state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      grant;
    logic                any_req;
    logic                space;
    logic                accept;
    logic [WIDTH-1:0]    a_sel;
    logic [WIDTH-1:0]    b_sel;
    logic [WIDTH:0]      full_sum;
    logic [WIDTH-1:0]    sum_out;
    logic [IDW-1:0]      ptr_next;

    // The buffer output simply reflects whether it currently holds a result.
    assign res_valid = (state == ST_FULL);

    // The buffer can take a new result in two cases.
    // - It is empty.
    // - The consumer is draining the current result this very cycle.
    assign space = !res_valid || res_ready;

    // Round-robin choice among the currently valid requesters.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_req)
    );

    // Ready goes only to the winner, and only when there is buffer space.
    // It depends on req_valid and res_ready, never on other ready bits.
    // Holding it low while rst_n is low keeps the block from signalling
    // acceptance during reset.
    always_comb begin
        req_ready = '0;
        if (any_req && space && rst_n) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Shared adder.
    // Operands of the winner are muxed in and added one bit wider to expose
    // the carry.
    // In saturating mode a carry clamps the visible sum to all-ones.
    // res_carry always reports the raw carry either way.
    always_comb begin
        a_sel    = req_a[grant*WIDTH +: WIDTH];
        b_sel    = req_b[grant*WIDTH +: WIDTH];
        full_sum = {1'b0, a_sel} + {1'b0, b_sel};
        sum_out  = full_sum[WIDTH-1:0];
        if ((SAT != 0) && full_sum[WIDTH]) begin
            sum_out = '1;
        end
    end

    // Priority moves to the requester just after the one served.
    // This rotates service fairly.
    // NREQ need not be a power of two, so the wrap is explicit.
    always_comb begin
        if (grant == IDW'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant + 1'b1;
        end
    end

    // Buffer state machine, result registers, priority pointer and counter.
    // The result registers only load on an accept, so they hold steady while
    // the buffer is full and stalled.
    // The pointer only moves on an accept, so an idle cycle never skips
    // anyone's turn.
    // The counter stops at its ceiling instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            rr_ptr    <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (res_ready && !accept) begin
                        state <= ST_EMPTY;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase

            if (accept) begin
                res_sum   <= sum_out;
                res_carry <= full_sum[WIDTH];
                res_id    <= grant;
                rr_ptr    <= ptr_next;
                if (op_count != OPCNT_MAX) begin
                    op_count <= op_count + 1'b1;
                end
            end
        end
    end

endmodule
